// File: rtl/gb_resp_pkg.sv
// Shared definitions for the generic-bus SRAM responder.
//   gb_resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   GB_BAD_RDATA    : default read data returned for out-of-range reads
//   GB_WAIT_CNT_W   : width of the wait-state counter (supports 0..15 waits)
package gb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } gb_resp_state_t;

  localparam logic [31:0] GB_BAD_RDATA  = 32'hBAD1_BAD1;
  localparam int          GB_WAIT_CNT_W = 4;

endpackage

// File: rtl/gb_sram_array.sv
// Word-organised storage behind the generic-bus responder.
// Ports:
//   AFT_CLK : clock, rising edge
//   we      : write strobe, commits enabled lanes at the clock edge
//   widx    : write word index
//   wdata   : write data
//   be      : byte lane enables, bit i covers wdata[8i+7:8i]
//   ridx    : read word index
//   rword   : combinational read data for ridx
// Contents are deliberately not reset.
module gb_sram_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           AFT_CLK,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] widx,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ridx,
  output logic [31:0]                    rword
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: only the enabled lanes of the addressed word change.
  always_ff @(posedge AFT_CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rword = mem[ridx];

endmodule

// File: rtl/gb_sram_responder.sv
// Generic-bus responder backed by a word-organised SRAM with programmable
// wait states. One transfer at a time; busy drops low for exactly one cycle
// when a transfer completes. Out-of-range accesses and simultaneous ren/wen
// set a sticky err flag.
// Ports:
//   AFT_CLK : clock, rising edge
//   nRST    : asynchronous active-low reset
//   ren/wen : read/write request, held by the master until completion
//   addr    : byte address (bits 1:0 ignored)
//   wdata   : write data
//   byte_en : write byte lane enables
//   rdata   : read data, non-zero only in the completion cycle
//   busy    : low only in the completion cycle
//   err     : sticky error flag
//   err_clr : synchronous clear of err (a simultaneous set wins)
module gb_sram_responder
  import gb_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BAD_RDATA   = GB_BAD_RDATA
) (
  input  logic        AFT_CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [GB_WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? GB_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  gb_resp_state_t           state_q, state_d;
  logic [GB_WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic        req;
  logic        write_q;
  logic        both_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [30:0]   word_off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic          mem_we;
  logic          err_set;
  logic          unused_addr_lsbs;

  assign req              = ren | wen;
  assign unused_addr_lsbs = ^addr[1:0];

  // Range check on word addresses. The extra top bit of word_off is the
  // borrow of the subtraction, so it flags addresses below BASE_ADDR; since
  // the depth is a power of two, anything at or beyond the top shows up as
  // a non-zero bit above the index field. The index is only the low bits.
  assign word_off = {1'b0, waddr_q} - {1'b0, BASE_ADDR[31:2]};
  assign in_range = ~word_off[30] && (word_off[29:AW] == '0);
  assign idx      = word_off[AW-1:0];

  gb_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .AFT_CLK(AFT_CLK),
    .we     (mem_we),
    .widx   (idx),
    .wdata  (wdata_q),
    .be     (be_q),
    .ridx   (idx),
    .rword  (rword)
  );

  // State and wait counter registers.
  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The request is captured once at accept so later changes on the bus
  // during the wait states cannot affect the transfer.
  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      write_q <= 1'b0;
      both_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state_q == IDLE && req) begin
      write_q <= wen;
      both_q  <= ren & wen;
      waddr_q <= addr[31:2];
      wdata_q <= wdata;
      be_q    <= byte_en;
    end
  end

  // Next-state and outputs. Dropping the request during WAIT abandons the
  // transfer silently; RESP always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b1;
    rdata   = '0;
    mem_we  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        busy    = 1'b0;
        state_d = IDLE;
        mem_we  = write_q && in_range;
        err_set = !in_range || both_q;
        if (!write_q) begin
          rdata = in_range ? rword : BAD_RDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a set in the same cycle as a clear wins.
  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_sram_responder.sv
// Self-checking bench for gb_sram_responder: a driver pushes expected
// responses from a behavioural memory model into a scoreboard queue, and a
// monitor pops and compares whenever busy drops. A second instance with no
// wait states covers back-to-back timing at the minimum period.
module tb_gb_sram_responder;
  import gb_resp_pkg::*;

  localparam int          WS      = 2;
  localparam int          DEPTH   = 256;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          TIMEOUT = 40;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          set_err;
    int          due;
  } exp_t;

  logic        AFT_CLK = 1'b0;
  logic        nRST    = 1'b0;
  logic        ren, wen, err_clr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byte_en;
  logic        busy, err;

  logic        z_ren, z_wen, z_err_clr;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_be;
  logic        z_busy, z_err;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          model_err = 1'b0;

  always #5 AFT_CLK = ~AFT_CLK;

  always @(posedge AFT_CLK) cyc <= cyc + 1;

  gb_sram_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .BAD_RDATA  (GB_BAD_RDATA)
  ) dut (
    .AFT_CLK(AFT_CLK),
    .nRST   (nRST),
    .ren    (ren),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .byte_en(byte_en),
    .rdata  (rdata),
    .busy   (busy),
    .err    (err),
    .err_clr(err_clr)
  );

  gb_sram_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(0),
    .BAD_RDATA  (GB_BAD_RDATA)
  ) dut_z (
    .AFT_CLK(AFT_CLK),
    .nRST   (nRST),
    .ren    (z_ren),
    .wen    (z_wen),
    .addr   (z_addr),
    .wdata  (z_wdata),
    .byte_en(z_be),
    .rdata  (z_rdata),
    .busy   (z_busy),
    .err    (z_err),
    .err_clr(z_err_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(BASE);
    return (la >= lb) && (la < lb + 64'(4 * DEPTH));
  endfunction

  task automatic waitDone();
    bit done = 1'b0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      @(negedge AFT_CLK);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL completion_timeout: busy stayed high for %0d cycles, required a completion",
               TIMEOUT);
      sb_q.delete();
    end
  endtask

  // Issue one transfer, predict its outcome from the memory model, and
  // return at the falling edge of the completion cycle with the request
  // still held so callers can chain back-to-back transfers.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               input logic clr);
    exp_t e;
    bit   ok;
    int   idx;
    @(posedge AFT_CLK);
    #1;
    ren     = r;
    wen     = w;
    addr    = a;
    wdata   = d;
    byte_en = be;
    err_clr = clr;
    ok      = inRange(a);
    idx     = int'((a - BASE) >> 2);
    e.is_read = !w;
    e.set_err = !ok || (r && w);
    e.due     = cyc + 1 + WS;
    e.data    = GB_BAD_RDATA;
    if (ok) begin
      e.data = model_mem[idx];
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    sb_q.push_back(e);
    waitDone();
  endtask

  task automatic releaseBus();
    @(posedge AFT_CLK);
    #1;
    ren     = 1'b0;
    wen     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic pulseErrClr();
    @(posedge AFT_CLK);
    #1 err_clr = 1'b1;
    @(posedge AFT_CLK);
    #1 err_clr = 1'b0;
  endtask

  // Start a write and withdraw it during the wait states.
  task automatic applyAbort(input logic [31:0] a, input logic [31:0] d);
    @(posedge AFT_CLK);
    #1;
    wen     = 1'b1;
    addr    = a;
    wdata   = d;
    byte_en = 4'hF;
    @(posedge AFT_CLK);
    #1 wen = 1'b0;
    repeat (WS + 3) @(posedge AFT_CLK);
  endtask

  // Zero-wait instance: two transfers with the request held throughout;
  // completions are expected in cycles 1 and 3 relative to the first cycle.
  task automatic zBackToBack(input logic w, input logic [31:0] d0, input logic [31:0] d1);
    z_ren   = !w;
    z_wen   = w;
    z_addr  = 32'h0;
    z_wdata = d0;
    z_be    = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge AFT_CLK);
      checkOutput($sformatf("z_busy_c%0d", c), 32'(z_busy), (c % 2 == 1) ? 32'd0 : 32'd1);
      if (!w) begin
        checkOutput($sformatf("z_rdata_c%0d", c), z_rdata,
                    (c == 1) ? d0 : ((c == 3) ? d1 : 32'h0));
      end
      @(posedge AFT_CLK);
      #1;
      if (c == 1) begin
        z_addr  = 32'h4;
        z_wdata = d1;
      end
    end
    z_ren = 1'b0;
    z_wen = 1'b0;
  endtask

  // Monitor: tracks the expected sticky error and checks every completion
  // against the head of the scoreboard.
  always @(negedge AFT_CLK) begin : monitor
    exp_t e;
    bit   set;
    if (!nRST) begin
      model_err = 1'b0;
    end else begin
      set = 1'b0;
      checkOutput("err_flag", 32'(err), 32'(model_err));
      if (busy) begin
        checkOutput("rdata_idle_zero", rdata, 32'h0);
      end else if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_completion: busy=0 at cycle %0d, required no completion",
                 cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("completion_cycle", 32'(cyc), 32'(e.due));
        if (e.is_read) checkOutput("read_data", rdata, e.data);
        set = e.set_err;
      end
      if (set) model_err = 1'b1;
      else if (err_clr) model_err = 1'b0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    logic [3:0]  be;
    logic        rr, ww, clr;
    int          sel;

    ren = 0; wen = 0; addr = 0; wdata = 0; byte_en = 0; err_clr = 0;
    z_ren = 0; z_wen = 0; z_addr = 0; z_wdata = 0; z_be = 0; z_err_clr = 0;

    #2;
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_err", 32'(err), 32'd0);
    repeat (2) @(posedge AFT_CLK);
    #1 nRST = 1'b1;

    $display("[TB] preloading all words back-to-back");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0);
    end
    releaseBus();

    $display("[TB] directed write/read and byte lanes");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    releaseBus();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    checkOutput("read_back_0x10", rdata, 32'hDEADBEEF);
    releaseBus();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0);
    releaseBus();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    releaseBus();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h3, 1'b0);
    checkOutput("byte_lane_merge", rdata, 32'h11BB33DD);
    releaseBus();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    releaseBus();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    checkOutput("empty_byte_en", rdata, 32'h11BB33DD);
    releaseBus();

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0);
    checkOutput("oor_read_data", rdata, 32'hBAD1BAD1);
    releaseBus();
    @(negedge AFT_CLK);
    checkOutput("oor_err_set", 32'(err), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h5555AAAA, 4'hF, 1'b0);
    releaseBus();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    releaseBus();
    pulseErrClr();
    @(negedge AFT_CLK);
    checkOutput("err_clr_clears", 32'(err), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 1'b1);
    releaseBus();
    @(negedge AFT_CLK);
    checkOutput("set_beats_clear", 32'(err), 32'd1);
    pulseErrClr();

    $display("[TB] abort during wait states");
    applyAbort(32'h40, 32'h0BADC0DE);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    releaseBus();

    $display("[TB] simultaneous ren and wen");
    applyStimulus(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b0);
    releaseBus();
    @(negedge AFT_CLK);
    checkOutput("both_req_err", 32'(err), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    checkOutput("both_req_written", rdata, 32'hCAFEF00D);
    releaseBus();
    pulseErrClr();

    $display("[TB] randomized transfers");
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 15));
      a   = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if (sel == 0) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63));
      if (sel == 3) a = 32'hF000_0000 | 32'($urandom_range(0, 255));
      ww  = 1'($urandom_range(0, 1));
      rr  = !ww || (sel == 1);
      be  = 4'($urandom_range(0, 15));
      clr = (sel == 2);
      applyStimulus(rr, ww, a, $urandom, be, clr);
      if ($urandom_range(0, 1) == 1) releaseBus();
    end
    releaseBus();

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
    releaseBus();
    @(posedge AFT_CLK);
    #1;
    wen     = 1'b1;
    addr    = 32'h30;
    wdata   = 32'h0BADF00D;
    byte_en = 4'hF;
    @(posedge AFT_CLK);
    #1 nRST = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd1);
    checkOutput("midreset_rdata", rdata, 32'h0);
    checkOutput("midreset_err", 32'(err), 32'd0);
    wen = 1'b0;
    @(posedge AFT_CLK);
    #1 nRST = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    releaseBus();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    checkOutput("after_reset_0x10", rdata, 32'hDEADBEEF);
    releaseBus();
    repeat (3) @(posedge AFT_CLK);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] zero-wait back-to-back");
    @(posedge AFT_CLK);
    #1;
    zBackToBack(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge AFT_CLK);
    #1;
    zBackToBack(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge AFT_CLK);
    checkOutput("z_err", 32'(z_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
